// File: rtl/d_cache_pkg.sv
// rtl/d_cache_pkg.sv - shared types, size codes and byte-lane helpers for d_cache_sa_wb
package d_cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RF   = 2'd2,
    UC   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Upper address bits of the uncached kernel segment
  localparam logic [2:0] KSEG1_PREFIX = 3'b101;

  // Byte lanes touched by a store of the given size at the given offset
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_mask = 4'b0001 << off;
      SZ_HALF: byte_mask = off[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  // Replace the masked byte lanes of old_word with those of new_word
  function automatic logic [31:0] merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                        input logic [3:0] mask);
    merge = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merge[8*b +: 8] = new_word[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/d_cache_way.sv
// rtl/d_cache_way.sv - one cache way: valid/dirty/tag/data arrays, combinational read, masked word write
module d_cache_way
  import d_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_WIDTH-1:0]  idx,
  input  logic [OFFSET_WIDTH-3:0] word,
  input  logic                    wr_en,
  input  logic [3:0]              wr_mask,
  input  logic [31:0]             wr_data,
  input  logic                    set_dirty,
  input  logic                    fill_en,
  input  logic [TAG_WIDTH-1:0]    fill_tag,
  output logic                    valid,
  output logic                    dirty,
  output logic [TAG_WIDTH-1:0]    tag,
  output logic [31:0]             rdata
);

  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int WORD_W     = OFFSET_WIDTH - 2;
  localparam int LINE_WORDS = 1 << WORD_W;

  logic [SETS-1:0]              valid_q;
  logic [SETS-1:0]              dirty_q;
  logic [TAG_WIDTH-1:0]         tag_mem  [SETS];
  logic [31:0]                  data_mem [SETS*LINE_WORDS];
  logic [INDEX_WIDTH+WORD_W-1:0] waddr;

  assign waddr = {idx, word};

  // Line status bits: cleared on reset, set by a completed refill, dirtied by a store hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en && set_dirty) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage are never reset; valid_q guards their contents
  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[idx] <= fill_tag;
    if (wr_en) data_mem[waddr] <= merge(data_mem[waddr], wr_data, wr_mask);
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_mem[idx];
  assign rdata = data_mem[waddr];

endmodule

// File: rtl/d_cache_sa_wb.sv
// rtl/d_cache_sa_wb.sv - set-associative write-back data cache; D_CACHE_UNCACHED_KSEG1_EN enables kseg1 bypass
module d_cache_sa_wb
  import d_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4,
  parameter int WAYS         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int TAG_W      = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_W     = OFFSET_WIDTH - 2;
  localparam int LINE_WORDS = 1 << WORD_W;
  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int PTR_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  // Request address fields
  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_W-1:0]      req_word;

  assign req_tag   = cpu_data_addr[31 -: TAG_W];
  assign req_index = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word  = cpu_data_addr[2 +: WORD_W];

  // Controller state
  state_t                 state;
  logic [WORD_W-1:0]      cnt;
  logic                   addr_rcv;
  logic [PTR_W-1:0]       victim_way;
  logic [TAG_W-1:0]       victim_tag;
  logic [TAG_W-1:0]       lat_tag;
  logic [INDEX_WIDTH-1:0] lat_index;
  logic [PTR_W-1:0]       rr_ptr [SETS];

  // Way array interface
  logic [WAYS-1:0]        w_valid;
  logic [WAYS-1:0]        w_dirty;
  logic [TAG_W-1:0]       w_tag   [WAYS];
  logic [31:0]            w_rdata [WAYS];
  logic [WAYS-1:0]        wr_en;
  logic [WAYS-1:0]        fill_en;
  logic [INDEX_WIDTH-1:0] way_idx;
  logic [WORD_W-1:0]      way_word;
  logic [31:0]            wr_data;
  logic [3:0]             wr_mask;

  logic                   uncached;
  logic                   hit;
  logic [PTR_W-1:0]       hit_way;
  logic [WAYS-1:0]        hit_vec;
  logic                   cache_hit;
  logic                   store_hit;
  logic [PTR_W-1:0]       vic;
  logic                   mem_done;
  logic                   fill;
  logic [PTR_W-1:0]       cur_ptr;
  logic [PTR_W-1:0]       next_ptr;

`ifdef D_CACHE_UNCACHED_KSEG1_EN
  assign uncached = (cpu_data_addr[31:29] == KSEG1_PREFIX);
`else
  assign uncached = 1'b0;
`endif

  // While idle the arrays follow the live request; during a miss they follow the latched line
  assign way_idx  = (state == IDLE) ? req_index : lat_index;
  assign way_word = (state == IDLE) ? req_word : cnt;

  assign mem_done = addr_rcv && cache_data_data_ok;
  assign fill     = (state == RF) && mem_done;

  assign cur_ptr  = rr_ptr[lat_index];
  assign next_ptr = (cur_ptr == PTR_W'(WAYS - 1)) ? '0 : cur_ptr + 1'b1;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = w_valid[w] && (w_tag[w] == req_tag);
      if (hit_vec[w]) begin
        hit     = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  assign cache_hit = (state == IDLE) && cpu_data_req && !uncached && hit;
  assign store_hit = cache_hit && cpu_data_wr;

  // Victim choice: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    vic = rr_ptr[req_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_valid[w]) vic = PTR_W'(w);
    end
  end

  // Per-way write enables: store hits on the matching way, refill words on the victim way
  always_comb begin
    wr_en   = '0;
    fill_en = '0;
    for (int w = 0; w < WAYS; w++) begin
      wr_en[w]   = (store_hit && (hit_way == PTR_W'(w))) || (fill && (victim_way == PTR_W'(w)));
      fill_en[w] = fill && (cnt == LAST_WORD) && (victim_way == PTR_W'(w));
    end
  end

  assign wr_data = (state == RF) ? cache_data_rdata : cpu_data_wdata;
  assign wr_mask = (state == RF) ? 4'b1111 : byte_mask(cpu_data_size, cpu_data_addr[1:0]);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    d_cache_way #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .OFFSET_WIDTH(OFFSET_WIDTH),
      .TAG_WIDTH   (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .idx      (way_idx),
      .word     (way_word),
      .wr_en    (wr_en[g]),
      .wr_mask  (wr_mask),
      .wr_data  (wr_data),
      .set_dirty(store_hit),
      .fill_en  (fill_en[g]),
      .fill_tag (lat_tag),
      .valid    (w_valid[g]),
      .dirty    (w_dirty[g]),
      .tag      (w_tag[g]),
      .rdata    (w_rdata[g])
    );
  end

  // Core and memory port drive, selected by controller state
  always_comb begin
    cpu_data_rdata   = '0;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'b00;
    cache_data_addr  = '0;
    cache_data_wdata = '0;
    case (state)
      IDLE: begin
        cpu_data_addr_ok = cache_hit;
        cpu_data_data_ok = cache_hit;
        cpu_data_rdata   = cache_hit ? w_rdata[hit_way] : '0;
      end
      WB: begin
        cache_data_req   = !addr_rcv;
        cache_data_wr    = 1'b1;
        cache_data_size  = SZ_WORD;
        cache_data_addr  = {victim_tag, lat_index, cnt, 2'b00};
        cache_data_wdata = w_rdata[victim_way];
      end
      RF: begin
        cache_data_req   = !addr_rcv;
        cache_data_size  = SZ_WORD;
        cache_data_addr  = {lat_tag, lat_index, cnt, 2'b00};
      end
      UC: begin
`ifdef D_CACHE_UNCACHED_KSEG1_EN
        cache_data_req   = !addr_rcv;
        cache_data_wr    = cpu_data_wr;
        cache_data_size  = cpu_data_size;
        cache_data_addr  = cpu_data_addr;
        cache_data_wdata = cpu_data_wdata;
        cpu_data_addr_ok = cache_data_addr_ok && !addr_rcv;
        cpu_data_data_ok = mem_done;
        cpu_data_rdata   = cache_data_rdata;
`endif
      end
      default: ;
    endcase
  end

  // Miss controller: writeback, refill and uncached phases, one memory transaction at a time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_rcv   <= 1'b0;
      victim_way <= '0;
      victim_tag <= '0;
      lat_tag    <= '0;
      lat_index  <= '0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_data_req && !cache_hit) begin
            if (uncached) begin
              state <= UC;
            end else begin
              victim_way <= vic;
              victim_tag <= w_tag[vic];
              lat_tag    <= req_tag;
              lat_index  <= req_index;
              cnt        <= '0;
              state      <= (w_valid[vic] && w_dirty[vic]) ? WB : RF;
            end
          end
        end
        WB, RF: begin
          if (cache_data_req && cache_data_addr_ok) addr_rcv <= 1'b1;
          if (mem_done) begin
            addr_rcv <= 1'b0;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_WORD) begin
              if (state == WB) begin
                state <= RF;
              end else begin
                rr_ptr[lat_index] <= next_ptr;
                state             <= IDLE;
              end
            end
          end
        end
        UC: begin
          if (cache_data_req && cache_data_addr_ok) addr_rcv <= 1'b1;
          if (mem_done) begin
            addr_rcv <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_sa_wb.sv
// tb/tb_d_cache_sa_wb.sv - directed scoreboard bench for d_cache_sa_wb
module tb_d_cache_sa_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;

  d_cache_sa_wb dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_data_req      (cpu_data_req),
    .cpu_data_wr       (cpu_data_wr),
    .cpu_data_size     (cpu_data_size),
    .cpu_data_addr     (cpu_data_addr),
    .cpu_data_wdata    (cpu_data_wdata),
    .cpu_data_rdata    (cpu_data_rdata),
    .cpu_data_addr_ok  (cpu_data_addr_ok),
    .cpu_data_data_ok  (cpu_data_data_ok),
    .cache_data_req    (cache_data_req),
    .cache_data_wr     (cache_data_wr),
    .cache_data_size   (cache_data_size),
    .cache_data_addr   (cache_data_addr),
    .cache_data_wdata  (cache_data_wdata),
    .cache_data_rdata  (cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok),
    .cache_data_data_ok(cache_data_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q [$];
  logic [31:0] cpu_q [$];
  logic [31:0] mem [logic [31:0]];
  int          tests = 0;
  int          fails = 0;
  int          mem_accepts = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
    txn_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  task automatic push_rd_line(input logic [31:0] base);
    for (int w = 0; w < 4; w++) push_txn(1'b0, 2'b10, base + 32'(4 * w), 32'h0);
  endtask

  // Memory: accept after one cycle, respond one idle cycle after acceptance
  initial begin
    txn_t t;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = '0;
    forever begin
      @(negedge clk); #1;
      if (rst && cache_data_req) begin
        chk("txn_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          chk("txn_wr", 32'(cache_data_wr), 32'(t.wr));
          chk("txn_size", 32'(cache_data_size), 32'(t.size));
          chk("txn_addr", cache_data_addr, t.addr);
          if (t.wr) chk("txn_wdata", cache_data_wdata, t.wdata);
        end
        t.wr = cache_data_wr; t.addr = cache_data_addr; t.wdata = cache_data_wdata;
        mem_accepts++;
        cache_data_addr_ok = 1'b1;
        @(negedge clk); #1;
        cache_data_addr_ok = 1'b0;
        @(negedge clk); #1;
        if (t.wr) mem[t.addr] = t.wdata;
        else cache_data_rdata = mem_rd(t.addr);
        cache_data_data_ok = 1'b1;
        @(negedge clk); #1;
        cache_data_data_ok = 1'b0;
        cache_data_rdata   = '0;
      end
    end
  end

  // One core access; exp_lat <= 0 skips the latency check
  task automatic cpu_op(input string tag, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int n_txn, input int exp_lat);
    int cyc = 0;
    bit got_addr = 0;
    bit got_data = 0;
    int acc0 = mem_accepts;
    logic [31:0] e;
    if (!wr) cpu_q.push_back(exp_rdata);
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = size;
    cpu_data_addr = addr; cpu_data_wdata = wdata;
    while (!got_data && cyc < 300) begin
      #3;
      cyc++;
      if (cpu_data_addr_ok) got_addr = 1;
      if (cpu_data_data_ok) begin
        got_data = 1;
        if (!wr && cpu_q.size() > 0) begin
          e = cpu_q.pop_front();
          chk({tag, "_rdata"}, cpu_data_rdata, e);
        end
      end
      @(negedge clk);
      if (got_addr) cpu_data_req = 1'b0;
    end
    cpu_data_req = 1'b0;
    chk({tag, "_done"}, 32'(got_data), 32'd1);
    chk({tag, "_accepted"}, 32'(got_addr), 32'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_mem_txns"}, 32'(mem_accepts - acc0), 32'(n_txn));
    chk({tag, "_txns_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdata"}, cpu_data_rdata, 32'h0);
    chk({tag, "_addr_ok"}, 32'(cpu_data_addr_ok), 32'h0);
    chk({tag, "_data_ok"}, 32'(cpu_data_data_ok), 32'h0);
    chk({tag, "_mreq"}, 32'(cache_data_req), 32'h0);
    chk({tag, "_mwr"}, 32'(cache_data_wr), 32'h0);
    chk({tag, "_msize"}, 32'(cache_data_size), 32'h0);
    chk({tag, "_maddr"}, cache_data_addr, 32'h0);
    chk({tag, "_mwdata"}, cache_data_wdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] A = 32'h0000_1010;
  localparam logic [31:0] B = 32'h0000_1810;
  localparam logic [31:0] C = 32'h0000_2010;
  localparam logic [31:0] D = 32'h0000_2810;

  initial begin
    int budget;
    rst = 1'b0;
    cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'b00;
    cpu_data_addr = '0; cpu_data_wdata = '0;
    mem[32'h1000] = 32'h11; mem[32'h1004] = 32'h22;
    mem[32'h1008] = 32'h33; mem[32'h100C] = 32'h44;

    repeat (3) @(negedge clk);
    #3 chk_idle_outputs("reset");
    @(negedge clk); rst = 1'b1;

    // Reset in the middle of a refill with the second read outstanding
    push_rd_line(32'h40);
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'b10; cpu_data_addr = 32'h40;
    budget = 0;
    while (mem_accepts < 2 && budget < 100) begin
      @(negedge clk); #3;
      budget++;
    end
    chk("rst_mid_second_read", 32'(mem_accepts), 32'd2);
    @(negedge clk);
    rst = 1'b0; cpu_data_req = 1'b0;
    #3 chk_idle_outputs("mid_reset");
    repeat (6) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    #3 chk_idle_outputs("post_reset");
    push_rd_line(32'h40);
    cpu_op("refetch_40", 1'b0, 2'b10, 32'h40, 32'h0, mem_rd(32'h40), 4, 0);

    // Clean load miss then hit
    push_rd_line(32'h1000);
    cpu_op("miss_1004", 1'b0, 2'b10, 32'h1004, 32'h0, 32'h22, 4, 0);
    cpu_op("hit_1004", 1'b0, 2'b10, 32'h1004, 32'h0, 32'h22, 0, 1);

    // Partial stores on a resident line
    cpu_op("st_byte_1005", 1'b1, 2'b00, 32'h1005, 32'h0000_AB00, 32'h0, 0, 1);
    cpu_op("ld_1004_byte", 1'b0, 2'b10, 32'h1004, 32'h0, 32'h0000_AB22, 0, 1);
    cpu_op("st_half_100a", 1'b1, 2'b01, 32'h100A, 32'hBEEF_0000, 32'h0, 0, 1);
    cpu_op("ld_1008_half", 1'b0, 2'b10, 32'h1008, 32'h0, 32'hBEEF_0033, 0, 1);

    // Set 0x01: dirty A in way 0, clean B in way 1, then C evicts A by pointer
    push_rd_line(A);
    cpu_op("fill_A", 1'b0, 2'b10, A, 32'h0, mem_rd(A), 4, 0);
    cpu_op("st_A4", 1'b1, 2'b10, A + 32'h4, 32'hDEAD_0001, 32'h0, 0, 1);
    push_rd_line(B);
    cpu_op("fill_B", 1'b0, 2'b10, B, 32'h0, mem_rd(B), 4, 0);
    push_txn(1'b1, 2'b10, A,          mem_rd(A));
    push_txn(1'b1, 2'b10, A + 32'h4,  32'hDEAD_0001);
    push_txn(1'b1, 2'b10, A + 32'h8,  mem_rd(A + 32'h8));
    push_txn(1'b1, 2'b10, A + 32'hC,  mem_rd(A + 32'hC));
    push_rd_line(C);
    cpu_op("evict_A_fill_C", 1'b0, 2'b10, C + 32'h4, 32'h0, mem_rd(C + 32'h4), 8, 0);
    push_rd_line(A);
    cpu_op("refill_A", 1'b0, 2'b10, A + 32'h4, 32'h0, 32'hDEAD_0001, 4, 0);

    // Two resident tags alternate without traffic; a third follows round-robin
    cpu_op("alt_C0", 1'b0, 2'b10, C, 32'h0, mem_rd(C), 0, 1);
    cpu_op("alt_A0", 1'b0, 2'b10, A + 32'h8, 32'h0, mem_rd(A + 32'h8), 0, 1);
    cpu_op("alt_C1", 1'b0, 2'b10, C + 32'hC, 32'h0, mem_rd(C + 32'hC), 0, 1);
    cpu_op("alt_A1", 1'b0, 2'b10, A + 32'h4, 32'h0, 32'hDEAD_0001, 0, 1);
    push_rd_line(D);
    cpu_op("fill_D", 1'b0, 2'b10, D, 32'h0, mem_rd(D), 4, 0);
    cpu_op("A_survives", 1'b0, 2'b10, A, 32'h0, mem_rd(A), 0, 1);
    push_rd_line(C);
    cpu_op("C_evicts_A", 1'b0, 2'b10, C, 32'h0, mem_rd(C), 4, 0);
    cpu_op("D_survives", 1'b0, 2'b10, D + 32'h8, 32'h0, mem_rd(D + 32'h8), 0, 1);

    // kseg1 half load
`ifdef D_CACHE_UNCACHED_KSEG1_EN
    push_txn(1'b0, 2'b01, 32'hA000_0002, 32'h0);
    cpu_op("uc_half", 1'b0, 2'b01, 32'hA000_0002, 32'h0, mem_rd(32'hA000_0002), 1, 0);
    push_txn(1'b0, 2'b01, 32'hA000_0002, 32'h0);
    cpu_op("uc_half_again", 1'b0, 2'b01, 32'hA000_0002, 32'h0, mem_rd(32'hA000_0002), 1, 0);
`else
    push_rd_line(32'hA000_0000);
    cpu_op("kseg1_cached", 1'b0, 2'b01, 32'hA000_0002, 32'h0, mem_rd(32'hA000_0000), 4, 0);
    cpu_op("kseg1_hit", 1'b0, 2'b01, 32'hA000_0002, 32'h0, mem_rd(32'hA000_0000), 0, 1);
`endif

    repeat (5) @(negedge clk);
    chk("final_txns_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
